dmem_axi_slave: RTL
===================

Name: dmem_axi_slave

Overview:
- On-chip data memory that consumes the core's AXI4-style data master port (AW/W/B/AR/R, no resp fields) and backs it with a word-organised SRAM array.
- Sits directly downstream of the core's memory stage.
- Serialises reads and writes through one FSM, with configurable read latency and byte-strobed writes.
- Always responds, including to out-of-range addresses, so the core's stall logic can never hang.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array (power of two, ≥16).
- READ_LATENCY, 1, cycles from AR handshake to rvalid (legal range 1..4).
- BASE_ADDR, 32'h0001_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- d_awvalid_i  in  1  write address valid
- d_awready_o  out  1  write address ready
- d_awaddr_i  in  32  write byte address
- d_awprot_i  in  3  protection (accepted, ignored)
- d_wvalid_i  in  1  write data valid
- d_wready_o  out  1  write data ready
- d_wdata_i  in  32  write data
- d_wstrb_i  in  4  byte-lane strobes
- d_bvalid_o  out  1  write response valid
- d_bready_i  in  1  write response ready
- d_arvalid_i  in  1  read address valid
- d_arready_o  out  1  read address ready
- d_araddr_i  in  32  read byte address
- d_arprot_i  in  3  protection (accepted, ignored)
- d_rvalid_o  out  1  read data valid
- d_rready_i  in  1  read data ready
- d_rdata_o  out  32  read data

Behaviour:
- Reset: one clock, asynchronous active-low reset rst_ni.
  - All readies, d_bvalid_o, d_rvalid_o = 0 and d_rdata_o = 0 while reset is asserted.
  - Pending AW/W latches are cleared and FSM goes to IDLE.
  - Array contents are not reset.
  - Reset mid-transaction discards the transaction; no B or R is issued afterwards.
- FSM states: IDLE, WR_COLLECT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE:
  - d_awready_o = d_wready_o = 1.
  - d_arready_o = 1 only when d_awvalid_i = 0 and d_wvalid_i = 0.
  - Write priority on simultaneous requests: AR stays unaccepted until the write completes.
- Write path:
  - AW and W are accepted independently, in either order.
  - Each is latched on handshake; its ready drops once latched (WR_COLLECT).
  - Array is written at the edge on which the second of the two handshakes completes (both in the same cycle is allowed).
  - Only lanes with wstrb = 1 are updated; wstrb = 0 commits nothing but still responds.
  - d_bvalid_o rises on the next cycle (WR_RESP) and holds until d_bready_i.
  - Return to IDLE after the B handshake.
- Read path:
  - AR handshake → RD_WAIT for READ_LATENCY-1 cycles → RD_RESP with d_rvalid_o = 1.
  - d_rdata_o is stable until the d_rready_i handshake, then back to IDLE.
- All readies are 0 in WR_RESP, RD_WAIT and RD_RESP.
- At most one transaction is in flight, so read-after-write to the same address always returns the new data.
- Addressing:
  - Index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits; addr[1:0] ignored.
  - Out of range (addr < BASE_ADDR or ≥ BASE_ADDR + 4*DEPTH_WORDS): write is dropped, read returns 32'h0, and the handshake timing is unchanged.
- Handshake rules: valids never depend on readies; readies may depend combinationally on input valids (AR gating only).

Optional Feature:
- Macro: DMEM_OOR_ERR_EN.
- Defined:
  - Adds port oor_err_o (out, 1): sticky, set the cycle after any out-of-range AW or AR handshake, cleared only by reset.
  - Adds port oor_addr_o (out, 32): captures the address of the first out-of-range access, reset value 0.
- Undefined: both ports and their logic are absent; out-of-range accesses are handled silently as above.

Test Plan:
- Reset, then AW+W in the same cycle, addr BASE+0x10, data 0xDEADBEEF, strb 0xF → d_bvalid_o = 1 on the next cycle. AR of BASE+0x10 → d_rvalid_o after READ_LATENCY cycles with d_rdata_o = 0xDEADBEEF.
- W (data 0x0000AA00, strb 0b0010) presented 2 cycles before AW to BASE+0x10 → d_wready_o drops after the W handshake; commit occurs at the AW handshake; readback = 0xDEADAAEF.
- d_bready_i held low 5 cycles while AR is pending → d_bvalid_o stays 1, all readies 0; AR is accepted only in the cycle after the B handshake.
- AR and AW+W to the same address asserted in the same IDLE cycle (data 0x12345678) → write accepted first, d_arready_o = 0; the following read returns 0x12345678. Then hold d_rready_i low 3 cycles → d_rdata_o stable throughout.
- Read of BASE+4*DEPTH_WORDS → d_rdata_o = 0, response delivered normally. With DMEM_OOR_ERR_EN: oor_err_o = 1 and oor_addr_o = BASE+4*DEPTH_WORDS.
- Assert rst_ni low while d_bvalid_o = 1 → d_bvalid_o falls immediately (asynchronously); after release, IDLE readies = 1 and no stale B is issued.

Source files
------------

// File: rtl/dmem_axi_slave.sv
// Word-organised data memory behind the core's AXI4-style data port; one transaction in flight.
// Optional DMEM_OOR_ERR_EN adds sticky out-of-range error reporting (oor_err_o, oor_addr_o).
module dmem_axi_slave #(
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        d_awvalid_i,
    output logic        d_awready_o,
    input  logic [31:0] d_awaddr_i,
    input  logic [2:0]  d_awprot_i,
    input  logic        d_wvalid_i,
    output logic        d_wready_o,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic        d_bvalid_o,
    input  logic        d_bready_i,
    input  logic        d_arvalid_i,
    output logic        d_arready_o,
    input  logic [31:0] d_araddr_i,
    input  logic [2:0]  d_arprot_i,
    output logic        d_rvalid_o,
    input  logic        d_rready_i,
    output logic [31:0] d_rdata_o
`ifdef DMEM_OOR_ERR_EN
    ,
    output logic        oor_err_o,
    output logic [31:0] oor_addr_o
`endif
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
    localparam logic [1:0]  LAT_INIT = 2'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

    typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_RESP, RD_WAIT, RD_RESP} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state;
    logic        awready_q, wready_q, idle_q, bvalid_q, rvalid_q;
    logic        aw_got, w_got;
    logic [1:0]  lat_cnt;
    logic [31:0] rdata_q, aw_addr_q, wdata_q, ar_addr_q;
    logic [3:0]  wstrb_q;

    logic        aw_hs, w_hs, ar_hs, wr_fire, mem_we;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] a);
        return in_range(a) ? mem[word_idx(a)] : 32'h0;
    endfunction

    // AR is held off while any write channel is active so writes win ties.
    assign d_awready_o = awready_q;
    assign d_wready_o  = wready_q;
    assign d_arready_o = idle_q & ~d_awvalid_i & ~d_wvalid_i;
    assign d_bvalid_o  = bvalid_q;
    assign d_rvalid_o  = rvalid_q;
    assign d_rdata_o   = rdata_q;

    assign aw_hs = d_awvalid_i & awready_q;
    assign w_hs  = d_wvalid_i & wready_q;
    assign ar_hs = d_arvalid_i & d_arready_o;

    // The array commits on the edge that completes the second of AW/W.
    assign wr_fire = (aw_hs | w_hs) & (aw_got | aw_hs) & (w_got | w_hs);
    assign wr_addr = aw_hs ? d_awaddr_i : aw_addr_q;
    assign wr_data = w_hs ? d_wdata_i : wdata_q;
    assign wr_strb = w_hs ? d_wstrb_i : wstrb_q;
    assign mem_we  = wr_fire & in_range(wr_addr);

    logic unused_ok;
    assign unused_ok = ^{d_awprot_i, d_arprot_i};

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_hs) aw_addr_q <= d_awaddr_i;
        if (w_hs) begin
            wdata_q <= d_wdata_i;
            wstrb_q <= d_wstrb_i;
        end
        if (ar_hs) ar_addr_q <= d_araddr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            idle_q    <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                IDLE, WR_COLLECT: begin
                    if (aw_hs) begin
                        aw_got    <= 1'b1;
                        awready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        w_got    <= 1'b1;
                        wready_q <= 1'b0;
                    end
                    if (wr_fire) begin
                        state     <= WR_RESP;
                        bvalid_q  <= 1'b1;
                        aw_got    <= 1'b0;
                        w_got     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        idle_q    <= 1'b0;
                    end else if (aw_hs || w_hs) begin
                        state  <= WR_COLLECT;
                        idle_q <= 1'b0;
                    end else if (ar_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        idle_q    <= 1'b0;
                        if (READ_LATENCY <= 1) begin
                            state    <= RD_RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= read_word(d_araddr_i);
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_INIT;
                        end
                    end else if (state == IDLE) begin
                        // Also raises the readies on the first cycle after reset.
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        idle_q    <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (d_bready_i) begin
                        state     <= IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        idle_q    <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        state    <= RD_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= read_word(ar_addr_q);
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RD_RESP: begin
                    if (d_rready_i) begin
                        state     <= IDLE;
                        rvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        idle_q    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_OOR_ERR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            oor_err_o  <= 1'b0;
            oor_addr_o <= '0;
        end else if (aw_hs && !in_range(d_awaddr_i)) begin
            oor_err_o <= 1'b1;
            if (!oor_err_o) oor_addr_o <= d_awaddr_i;
        end else if (ar_hs && !in_range(d_araddr_i)) begin
            oor_err_o <= 1'b1;
            if (!oor_err_o) oor_addr_o <= d_araddr_i;
        end
    end
`endif

endmodule
